// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the junction controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    SUB_GREEN,
    SUB_YELLOW
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module traffic_rr_arbiter #(
  parameter int NUM_SUB = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_SUB-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_SUB; k++) begin
      automatic int unsigned pos = (int'(ptr) + k) % NUM_SUB;
      if (!any && req[pos]) begin
        idx = IDX_W'(pos);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Highway/side-road junction controller with round-robin side service and train preemption.
// Optional build macro SUB_EXTEND_EN: vehicle-driven side-green extension up to MAX_EXT_CYCLES.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_SUB          = 2,
  parameter int MIN_MAIN_CYCLES  = 10,
  parameter int YELLOW_CYCLES    = 3,
  parameter int SUB_GREEN_CYCLES = 8,
  parameter int MAX_EXT_CYCLES   = 8,
  localparam int IDX_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sen_train,
  input  logic [NUM_SUB-1:0]     sen_sub,
  output logic [2:0]             main_lights,
  output logic [3*NUM_SUB-1:0]   sub_lights,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid,
  output logic [NUM_SUB-1:0]     req_pending
);

  localparam int MAX_DUR_A = (MIN_MAIN_CYCLES > YELLOW_CYCLES) ? MIN_MAIN_CYCLES : YELLOW_CYCLES;
  localparam int MAX_DUR_B = SUB_GREEN_CYCLES + MAX_EXT_CYCLES;
  localparam int MAX_DUR   = (MAX_DUR_A > MAX_DUR_B) ? MAX_DUR_A : MAX_DUR_B;
  localparam int CNT_W     = $clog2(MAX_DUR + 1);

  localparam logic [CNT_W-1:0] MAIN_LAST = CNT_W'(MIN_MAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] SG_LAST   = CNT_W'(SUB_GREEN_CYCLES - 1);
`ifdef SUB_EXTEND_EN
  localparam logic [CNT_W-1:0] EXT_LAST  = CNT_W'(SUB_GREEN_CYCLES + MAX_EXT_CYCLES - 1);
`endif

  if (NUM_SUB < 1 || NUM_SUB > 8 || MIN_MAIN_CYCLES < 1 || YELLOW_CYCLES < 1 ||
      SUB_GREEN_CYCLES < 1 || MAX_EXT_CYCLES < 1) begin : g_bad_cfg
    $error("traffic_junction_ctrl: parameter out of range");
  end

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               take_grant, enter_sub, sub_done;
  logic [NUM_SUB-1:0] req_n;

  traffic_rr_arbiter #(
    .NUM_SUB (NUM_SUB),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req_pending),
    .ptr (ptr),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
`ifdef SUB_EXTEND_EN
    // Past the base boundary, green holds while the granted road still sees traffic, up to the cap.
    sub_done = (cnt >= SG_LAST) && (!sen_sub[grant_idx] || cnt >= EXT_LAST);
`else
    sub_done = (cnt == SG_LAST);
`endif
    state_n    = state;
    take_grant = 1'b0;
    enter_sub  = 1'b0;
    case (state)
      MAIN_GREEN:
        if (cnt >= MAIN_LAST && arb_any && !sen_train) begin
          state_n    = MAIN_YELLOW;
          take_grant = 1'b1;
        end
      MAIN_YELLOW:
        if (sen_train) begin
          state_n = MAIN_GREEN;
        end else if (cnt == YEL_LAST) begin
          state_n   = SUB_GREEN;
          enter_sub = 1'b1;
        end
      SUB_GREEN:
        if (sen_train || sub_done) state_n = SUB_YELLOW;
      SUB_YELLOW:
        if (cnt == YEL_LAST) state_n = MAIN_GREEN;
      default: state_n = MAIN_GREEN;
    endcase

    req_n = req_pending;
    if (enter_sub) req_n[grant_idx] = 1'b0;
    req_n = req_n | sen_sub;

    ptr_n = (grant_idx == IDX_W'(NUM_SUB - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MAIN_GREEN;
      cnt         <= '0;
      req_pending <= '0;
      grant_idx   <= '0;
      ptr         <= '0;
    end else begin
      state       <= state_n;
      req_pending <= req_n;
      if (state_n != state) cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + 1'b1;
      if (take_grant) grant_idx <= arb_idx;
      if (enter_sub)  ptr       <= ptr_n;
    end
  end

  always_comb begin
    main_lights = LIGHT_RED;
    sub_lights  = {NUM_SUB{LIGHT_RED}};
    grant_valid = 1'b0;
    case (state)
      MAIN_GREEN:  main_lights = LIGHT_GREEN;
      MAIN_YELLOW: main_lights = LIGHT_YELLOW;
      SUB_GREEN: begin
        sub_lights[3*int'(grant_idx) +: 3] = LIGHT_GREEN;
        grant_valid = 1'b1;
      end
      SUB_YELLOW: begin
        sub_lights[3*int'(grant_idx) +: 3] = LIGHT_YELLOW;
        grant_valid = 1'b1;
      end
      default: main_lights = LIGHT_RED;
    endcase
  end

endmodule
